signed_alu_arbiter: RTL and testbench

Shares one signed arithmetic unit (add, subtract, multiply, compare) among `NREQ` requesters. Each requester presents an opcode and two signed operands with a valid/ready handshake. A round-robin arbiter grants one request at a time, and a small FSM sequences the operation: add, subtract and compare take one cycle, multiply takes two. Results leave through a single-entry output register, tagged with the requester ID. The block sits between the sequencing logic and the signed datapath, so a single multiplier serves every client.

---
 rtl/signed_alu_pkg.sv | 30 +++
 rtl/signed_alu_arbiter_rr_arbiter.sv | 39 +++
 rtl/signed_alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_signed_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_alu_pkg.sv
// Shared types and helpers for the arbitrated signed ALU: opcodes, sequencer
// states and saturation bounds. SIGNED_ALU_SAT_EN selects saturating ADD/SUB.
package signed_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_CMP = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FULL = 2'd2
    } alu_state_t;

    localparam int SAT_CALC_BITS = 64;

    // Largest positive two's-complement value of a w-bit word.
    function automatic logic [SAT_CALC_BITS-1:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word.
    function automatic logic [SAT_CALC_BITS-1:0] sat_neg(input int w);
        return ~sat_pos(w);
    endfunction

endpackage

// File: rtl/signed_alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int idx;
        gnt     = {NREQ{1'b0}};
        gnt_idx = {IDW{1'b0}};
        found_s = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found_s && req[idx]) begin
                found_s = 1'b1;
                gnt_idx = IDW'(idx);
            end else begin
                found_s = found_s;
            end
        end
        if (en && found_s) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/signed_alu_arbiter.sv
// Shared signed ADD/SUB/MUL/CMP unit behind a round-robin arbiter with a
// single-entry response register. Define SIGNED_ALU_SAT_EN for saturating ADD/SUB.
module signed_alu_arbiter
    import signed_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*2-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_result,
    output logic                  rsp_lt,
    output logic                  rsp_gt,
    output logic                  rsp_ovf
);

`ifdef SIGNED_ALU_SAT_EN
    localparam logic [SAT_CALC_BITS-1:0] SAT_POS_WIDE = sat_pos(WIDTH);
    localparam logic [SAT_CALC_BITS-1:0] SAT_NEG_WIDE = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0]         SAT_POS      = SAT_POS_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]         SAT_NEG      = SAT_NEG_WIDE[WIDTH-1:0];
`endif

    alu_state_t              state_r;
    logic [IDW-1:0]          ptr_r;
    logic [IDW-1:0]          gnt_idx_s;
    logic [NREQ-1:0]         gnt_s;
    logic                    can_accept_s;
    logic                    accept_s;
    alu_op_t                 sel_op_s;
    logic signed [WIDTH-1:0] sel_a_s;
    logic signed [WIDTH-1:0] sel_b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0]        arith_w_s;
    logic [WIDTH-1:0]        final_w_s;
    logic                    ovf_s;
    logic [2*WIDTH-1:0]      arith_res_s;
    logic [2*WIDTH-1:0]      prod_s;
    logic signed [WIDTH-1:0] mul_a_r;
    logic signed [WIDTH-1:0] mul_b_r;
    logic [IDW-1:0]          mul_id_r;

    assign can_accept_s = !rst && ((state_r == ST_IDLE) || ((state_r == ST_FULL) && rsp_ready));

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .en      (can_accept_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign req_ready = gnt_s;
    assign accept_s  = |gnt_s;

    // Steer the granted requester's opcode and operands into the datapath.
    always_comb begin
        sel_op_s = alu_op_t'(req_op[2*int'(gnt_idx_s) +: 2]);
        sel_a_s  = req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
        sel_b_s  = req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];
    end

    // Single-cycle ADD/SUB with overflow detection, optional saturation, sign extension.
    always_comb begin
        sum_s  = sel_a_s + sel_b_s;
        diff_s = sel_a_s - sel_b_s;
        case (sel_op_s)
            OP_ADD: begin
                arith_w_s = sum_s;
                ovf_s     = (sel_a_s[WIDTH-1] == sel_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != sel_a_s[WIDTH-1]);
            end
            OP_SUB: begin
                arith_w_s = diff_s;
                ovf_s     = (sel_a_s[WIDTH-1] != sel_b_s[WIDTH-1]) && (diff_s[WIDTH-1] != sel_a_s[WIDTH-1]);
            end
            default: begin
                arith_w_s = {WIDTH{1'b0}};
                ovf_s     = 1'b0;
            end
        endcase
`ifdef SIGNED_ALU_SAT_EN
        // Overflow direction always follows the sign of operand a.
        if (ovf_s) begin
            final_w_s = sel_a_s[WIDTH-1] ? SAT_NEG : SAT_POS;
        end else begin
            final_w_s = arith_w_s;
        end
`else
        final_w_s = arith_w_s;
`endif
        arith_res_s = {{WIDTH{final_w_s[WIDTH-1]}}, final_w_s};
    end

    // Low 2*WIDTH bits of the product of sign-extended operands are the signed product.
    assign prod_s = {{WIDTH{mul_a_r[WIDTH-1]}}, mul_a_r} * {{WIDTH{mul_b_r[WIDTH-1]}}, mul_b_r};

    // Sequencer, round-robin pointer and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IDW{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_id     <= {IDW{1'b0}};
            rsp_result <= {(2*WIDTH){1'b0}};
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_ovf    <= 1'b0;
            mul_a_r    <= {WIDTH{1'b0}};
            mul_b_r    <= {WIDTH{1'b0}};
            mul_id_r   <= {IDW{1'b0}};
        end else begin
            if (accept_s) begin
                ptr_r <= (gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1);
            end
            case (state_r)
                ST_IDLE, ST_FULL: begin
                    if (accept_s && (sel_op_s == OP_MUL)) begin
                        state_r   <= ST_MUL;
                        rsp_valid <= 1'b0;
                        mul_a_r   <= sel_a_s;
                        mul_b_r   <= sel_b_s;
                        mul_id_r  <= gnt_idx_s;
                    end else if (accept_s) begin
                        state_r    <= ST_FULL;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= gnt_idx_s;
                        rsp_result <= arith_res_s;
                        rsp_lt     <= sel_a_s < sel_b_s;
                        rsp_gt     <= sel_a_s > sel_b_s;
                        rsp_ovf    <= ovf_s;
                    end else if ((state_r == ST_FULL) && rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    state_r    <= ST_FULL;
                    rsp_valid  <= 1'b1;
                    rsp_id     <= mul_id_r;
                    rsp_result <= prod_s;
                    rsp_lt     <= mul_a_r < mul_b_r;
                    rsp_gt     <= mul_a_r > mul_b_r;
                    rsp_ovf    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_alu_arbiter.sv
// Self-checking bench for signed_alu_arbiter: directed vector table, random
// operations against an arithmetic model, and arbitration/backpressure/reset sequences.
module tb_signed_alu_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef SIGNED_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*2-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [2*W-1:0] rsp_result;
    logic           rsp_lt;
    logic           rsp_gt;
    logic           rsp_ovf;

    int total  = 0;
    int passed = 0;

    signed_alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_lt     (rsp_lt),
        .rsp_gt     (rsp_gt),
        .rsp_ovf    (rsp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         op;
        int         a;
        int         b;
        logic [15:0] res;
        logic       lt;
        logic       gt;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, then wrap or clamp to W bits.
    function automatic void model(input int op, input int a, input int b,
                                  output logic [15:0] res, output logic lt,
                                  output logic gt, output logic ovf);
        int s;
        int w;
        lt  = a < b;
        gt  = a > b;
        ovf = 1'b0;
        res = 16'h0000;
        case (op)
            0, 1: begin
                s   = (op == 0) ? a + b : a - b;
                ovf = (s > 127) || (s < -128);
                w   = (s + 512) % 256;
                if (w > 127) w = w - 256;
                if (SAT && ovf) w = (s > 0) ? 127 : -128;
                res = w[15:0];
            end
            2: begin
                s   = a * b;
                res = s[15:0];
            end
            default: res = 16'h0000;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " rsp_valid"},  rsp_valid,  0);
        check({tag, " rsp_id"},     rsp_id,     0);
        check({tag, " rsp_result"}, rsp_result, 0);
        check({tag, " flags"},      {rsp_lt, rsp_gt, rsp_ovf}, 0);
        check({tag, " req_ready"},  req_ready,  0);
    endtask

    // Issue one operation from a single requester starting in IDLE at a negedge.
    task automatic apply(input int id, input int op, input int a, input int b,
                         input logic [15:0] eres, input logic elt, input logic egt,
                         input logic eovf, input string name);
        logic [N-1:0] oh;
        int lat;
        bit got;
        oh = 4'b0001 << id;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_op[2*id +: 2] = op[1:0];
        req_a[W*id +: W]  = a[7:0];
        req_b[W*id +: W]  = b[7:0];
        rsp_ready = 1'b1;
        #1;
        check({name, " grant"}, req_ready, oh);
        @(posedge clk);
        #1 req_valid = '0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
            end else if (lat == 1) begin
                req_valid = '1;
                #1;
                check({name, " busy ready"}, req_ready, 0);
                req_valid = '0;
            end
        end
        check({name, " latency"}, lat, (op == 2) ? 2 : 1);
        check({name, " id"},      rsp_id, id);
        check({name, " result"},  rsp_result, eres);
        check({name, " flags"},   {rsp_lt, rsp_gt, rsp_ovf}, {elt, egt, eovf});
        @(posedge clk);
        @(negedge clk);
        check({name, " drained"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] mres;
        logic mlt, mgt, movf;
        int id, op, a, b;

        vecs[0] = '{1, 0,  100,   50, SAT ? 16'h007F : 16'hFF96, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{0, 2, -128, -128, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2, 3,   -3,    2, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3, 3,    5,    5, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{0, 1, -100,   50, SAT ? 16'hFF80 : 16'h006A, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{2, 1,   10,   20, 16'hFFF6, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{3, 2,  127, -128, 16'hC080, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1, 0, -128,   -1, SAT ? 16'hFF80 : 16'h007F, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after reset");

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].lt, vecs[i].gt, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            id = $urandom_range(0, 3);
            op = $urandom_range(0, 3);
            a  = int'($urandom_range(0, 255)) - 128;
            b  = int'($urandom_range(0, 255)) - 128;
            model(op, a, b, mres, mlt, mgt, movf);
            apply(id, op, a, b, mres, mlt, mgt, movf, $sformatf("rand%0d", i));
        end

        // Round-robin with all requesters active, starting from a fresh pointer.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'd0;
            req_a[W*i +: W]  = 8'(10*i + 3);
            req_b[W*i +: W]  = 8'd1;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr grant%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k > 0) begin
                check($sformatf("rr valid%0d", k), rsp_valid, 1);
                check($sformatf("rr id%0d", k), rsp_id, (k - 1) % 4);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Backpressure: response from requester 0 (3+1) must hold for 5 cycles.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp ready%0d", k), req_ready, 0);
            check($sformatf("bp hold%0d", k), {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd0, 16'd4});
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp release grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("bp next rsp", {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd1, 16'd14});
        @(posedge clk);
        @(negedge clk);

        // Reset while a multiply is in flight.
        req_valid[2] = 1'b1;
        req_op[5:4]  = 2'd2;
        req_a[23:16] = 8'd7;
        req_b[23:16] = 8'd9;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("mulrst in flight", rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("mulrst reset");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mulrst no rsp%0d", k), {rsp_valid, rsp_id, rsp_result}, 0);
        end
        req_valid = '1;
        #1;
        check("mulrst ptr", req_ready, 4'b0001);
        req_valid = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
